// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: issues sequential imem reads and buffers the returned
// words, tagged with their fetch address, in a small FIFO for the execute stage.
module instr_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [AW-1:0]           start_pc,
    input  logic                    redirect,
    input  logic [AW-1:0]           redirect_pc,
    output logic                    imem_req,
    output logic [AW-1:0]           imem_addr,
    input  logic [31:0]             imem_rdata,
    output logic [31:0]             instr,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [AW-1:0]           pc_out,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned CW1 = CW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t          state;
    logic [AW-1:0]   fetch_pc;
    logic [AW-1:0]   resp_addr;
    logic            inflight;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [31:0]     mem_instr [DEPTH];
    logic [AW-1:0]   mem_pc    [DEPTH];

    logic            push;
    logic            pop;
    logic            halt;
    logic            req_nxt;
    logic [CW-1:0]   count_nxt;

    // Head of queue is presented combinationally; zero when empty.
    always_comb begin
        instr_valid = (count != '0);
        instr       = instr_valid ? mem_instr[head] : '0;
        pc_out      = instr_valid ? mem_pc[head] : '0;
        busy        = (state != IDLE);
        pop         = instr_valid && instr_ready;
        push        = (state == FETCH) && inflight;
        halt        = push && (imem_rdata[5:0] == 6'h3F);
        count_nxt   = count + CW'(push) - CW'(pop);
        // Reserve a slot for every request whose response has not been pushed yet.
        req_nxt     = (state == FETCH) && !halt &&
                      ((CW1'(count_nxt) + CW1'(imem_req)) < CW1'(DEPTH));
    end

    // Queue storage carries no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !redirect) begin
            mem_instr[tail] <= imem_rdata;
            mem_pc[tail]    <= resp_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fetch_pc  <= '0;
            resp_addr <= '0;
            inflight  <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else if (redirect) begin
            // Flush everything, including the response due next cycle.
            state     <= FETCH;
            fetch_pc  <= redirect_pc;
            resp_addr <= imem_addr;
            inflight  <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            imem_req  <= 1'b0;
        end else begin
            inflight  <= imem_req;
            resp_addr <= imem_addr;
            count     <= count_nxt;
            imem_req  <= req_nxt;
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (req_nxt) begin
                imem_addr <= fetch_pc;
                fetch_pc  <= fetch_pc + AW'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        fetch_pc <= start_pc;
                    end
                end
                FETCH: begin
                    if (halt) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((count == '0) && !inflight && !imem_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: memory responder, stream-level reference model
// and a scoreboard monitor that checks every delivered instruction and request.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  start_pc;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  pc_out;
    logic        busy;
    logic [2:0]  count;

    instr_fetch_queue #(.DEPTH(DEPTH), .AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_out(pc_out), .busy(busy), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory image: distinct words, opcode 3F only at the chosen halt address.
    logic       halt_en;
    logic [7:0] halt_addr;

    function automatic logic [31:0] word_at(input logic [7:0] a);
        logic [5:0] opc;
        opc = (halt_en && a == halt_addr) ? 6'h3F : 6'(a % 8'd63);
        return {8'hA5, a, ~a, 2'b01, opc};
    endfunction

    // Responder: data for a request appears exactly one cycle later.
    logic       r_req;
    logic [7:0] r_addr;
    always begin
        @(negedge clk);
        r_req  = imem_req;
        r_addr = imem_addr;
        @(posedge clk);
        #1;
        imem_rdata = r_req ? word_at(r_addr) : $urandom;
    end

    // Reference model: the instruction stream expected from a given start address.
    typedef struct {
        logic [7:0]  pc;
        logic [31:0] w;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] seen_pc[$];
    logic [7:0] req_next;
    int         req_budget;

    function automatic void load_stream(input logic [7:0] p);
        exp_q.delete();
        seen_pc.delete();
        req_next   = p;
        req_budget = -1;
        for (int i = 0; i < 1024; i++) begin
            logic [7:0] a;
            a = p + 8'(i);
            exp_q.push_back('{a, word_at(a)});
            if (halt_en && a == halt_addr) begin
                req_budget = i + 2;  // stream up to halt, plus one request already issued
                break;
            end
        end
    endfunction

    logic        have_prev;
    logic [31:0] prev_instr;
    logic [7:0]  prev_pc;

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            req_budget = 0;
            have_prev  = 1'b0;
        end else begin
            if (have_prev) begin
                chk("hold_valid", instr_valid, 1);
                chk("hold_instr", instr, prev_instr);
                chk("hold_pc", pc_out, prev_pc);
            end
            if (instr_valid && instr_ready) begin
                chk("pop_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pop_pc", pc_out, e.pc);
                    chk("pop_instr", instr, e.w);
                    seen_pc.push_back(pc_out);
                end
            end
            if (imem_req) begin
                chk("req_allowed", 32'(req_budget != 0), 1);
                chk("req_addr", imem_addr, req_next);
                req_next = req_next + 8'd1;
                if (req_budget > 0) req_budget--;
            end
            chk("count_bound", 32'(count <= 3'(DEPTH)), 1);
            chk("valid_vs_count", instr_valid, 32'(count != 3'd0));
            have_prev  = instr_valid && !instr_ready && !redirect;
            prev_instr = instr;
            prev_pc    = pc_out;
            if (redirect) load_stream(redirect_pc);
            else if (start) load_stream(start_pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_imem_req"}, imem_req, 0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_instr_valid"}, instr_valid, 0);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_pc_out"}, pc_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_count"}, count, 0);
    endtask

    initial begin
        logic        found;
        logic        last_req;
        logic [31:0] saved_instr;
        logic [7:0]  saved_pc;

        rst_n = 1'b0; start = 1'b0; start_pc = '0; redirect = 1'b0; redirect_pc = '0;
        instr_ready = 1'b0; halt_en = 1'b0; halt_addr = '0; imem_rdata = '0;
        repeat (2) tick();
        chk_all_zero("reset");
        @(negedge clk); #2 rst_n = 1'b1;
        tick();

        // Halt stream with latency check: start at edge N.
        halt_en = 1'b1; halt_addr = 8'h13; instr_ready = 1'b1;
        start = 1'b1; start_pc = 8'h10;
        @(posedge clk); #1 start = 1'b0;
        chk("lat_busy", busy, 1);
        tick();
        chk("lat_req", imem_req, 1);
        chk("lat_addr", imem_addr, 8'h10);
        tick();
        chk("lat_not_yet_valid", instr_valid, 0);
        tick();
        chk("lat_valid", instr_valid, 1);
        chk("lat_pc", pc_out, 8'h10);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (count == 3'd0) begin found = 1'b1; break; end
            tick();
        end
        chk("halt_empties", found, 1);
        chk("halt_busy_at_empty", busy, 1);
        tick();
        chk("halt_busy_falls", busy, 0);
        chk("halt_all_delivered", 32'(exp_q.size()), 0);
        chk("halt_last_pc", 32'(seen_pc.size() != 0 ? seen_pc[$] : 8'h00), 8'h13);

        // Streaming without halt.
        halt_en = 1'b0;
        start = 1'b1; start_pc = 8'h10;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 20; i++) begin
            chk("stream_valid", instr_valid, 1);
            chk("stream_count_le2", 32'(count <= 3'd2), 1);
            tick();
        end

        // Backpressure: queue fills and holds.
        instr_ready = 1'b0;
        repeat (8) tick();
        chk("bp_full", count, DEPTH);
        chk("bp_no_req", imem_req, 0);
        saved_instr = instr; saved_pc = pc_out;
        repeat (3) tick();
        chk("bp_full_hold", count, DEPTH);
        chk("bp_no_req_hold", imem_req, 0);
        chk("bp_instr_stable", instr, saved_instr);
        chk("bp_pc_stable", pc_out, saved_pc);
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain_valid", instr_valid, 1);
            tick();
        end
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req) begin found = 1'b1; break; end
            tick();
        end
        chk("bp_resume_req", found, 1);

        // Redirect with three queued entries and one response in flight.
        instr_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 8'h30;
        tick();
        redirect = 1'b0;
        chk("redir1_flush", count, 0);
        found = 1'b0; last_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (count == 3'd3) begin found = 1'b1; break; end
            last_req = imem_req;
            tick();
        end
        chk("redir_setup_count3", found, 1);
        chk("redir_setup_inflight", last_req, 1);
        redirect = 1'b1; redirect_pc = 8'h40;
        tick();
        redirect = 1'b0;
        chk("redir2_flush", count, 0);
        chk("redir2_not_valid", instr_valid, 0);
        instr_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (instr_valid) begin found = 1'b1; break; end
            tick();
        end
        chk("redir2_refill", found, 1);
        chk("redir2_first_pc", pc_out, 8'h40);

        // Random backpressure and redirects.
        for (int i = 0; i < 300; i++) begin
            instr_ready = ($urandom % 4) != 0;
            if (($urandom % 25) == 0) begin
                redirect = 1'b1;
                redirect_pc = 8'($urandom);
            end
            tick();
            redirect = 1'b0;
        end

        // Asynchronous reset mid-stream, then restart across the address wrap.
        instr_ready = 1'b1;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk); #2 rst_n = 1'b1;
        tick();
        chk("post_rst_count", count, 0);
        chk("post_rst_busy", busy, 0);
        start = 1'b1; start_pc = 8'hFE;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("wrap_seen4", 32'(seen_pc.size() >= 4), 1);
        if (seen_pc.size() >= 4) begin
            chk("wrap_pc0", seen_pc[0], 8'hFE);
            chk("wrap_pc1", seen_pc[1], 8'hFF);
            chk("wrap_pc2", seen_pc[2], 8'h00);
            chk("wrap_pc3", seen_pc[3], 8'h01);
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 Parameter AW, default 8, instruction address width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  pulse, begin fetching at start_pc.
REQ-006 start_pc  input  AW  first fetch address.
REQ-007 redirect  input  1  pulse, flush queue and refetch from redirect_pc.
REQ-008 redirect_pc  input  AW  new fetch address.
REQ-009 imem_req  output  1  instruction-memory read strobe.
REQ-010 imem_addr  output  AW  read address, valid with imem_req.
REQ-011 imem_rdata  input  32  read data, valid exactly one cycle after imem_req.
REQ-012 instr  output  32  head-of-queue instruction to execute stage (opcode in [5:0]).
REQ-013 instr_valid  output  1  instr/pc_out valid.
REQ-014 instr_ready  input  1  execute stage accepts instr.
REQ-015 pc_out  output  AW  fetch address of instr.
REQ-016 busy  output  1  state != IDLE.
REQ-017 count  output  $clog2(DEPTH)+1  occupied queue entries.

Function
REQ-018 FSM states IDLE, FETCH, DRAIN; IDLE->FETCH on start, FETCH->DRAIN on halt capture, DRAIN->IDLE when queue empty and no request in flight.
REQ-019 start SHALL be ignored outside IDLE; on start, fetch pc loads start_pc.
REQ-020 In FETCH, imem_req SHALL assert when count + inflight < DEPTH (inflight = imem_req of previous cycle); back-to-back requests allowed.
REQ-021 Each request SHALL increment fetch pc by 1, modulo 2^AW (AW'hFF wraps to 0).
REQ-022 Response SHALL be written to queue tail one cycle after its request, tagged with its request address; push never occurs when full (guaranteed by REQ-020).
REQ-023 Halt: response with imem_rdata[5:0] == 6'h3F SHALL be enqueued, SHALL inhibit imem_req from that same cycle, and SHALL move FSM to DRAIN; response to a request issued same cycle is discarded.
REQ-024 instr/pc_out SHALL show queue head combinationally; instr_valid = (count != 0); pop on instr_valid & instr_ready.
REQ-025 Simultaneous push and pop SHALL leave count unchanged, including at count == DEPTH-1 and count == 1 with valid pop.
REQ-026 No pop when empty; instr_ready with instr_valid low has no effect.
REQ-027 Hold: instr, pc_out stable while instr_valid & !instr_ready.
REQ-028 redirect (any state) SHALL, next edge: empty queue, drop any in-flight response, load fetch pc = redirect_pc, enter FETCH; first new request the cycle after.
REQ-029 redirect has priority over start, halt, push; a pop in the redirect cycle counts as accepted by consumer, then flushed state applies.
REQ-030 Latency: start at edge N -> imem_req at N+1 -> instr_valid at N+3 with pc_out = start_pc.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, fetch pc 0, queue empty, inflight 0, imem_req 0, imem_addr 0, instr_valid 0, instr 0, pc_out 0, busy 0, count 0.
REQ-032 Reset mid-operation SHALL discard any in-flight response; no write occurs on the first edge after release.

Verification
REQ-033 Streaming: start_pc=8'h10, instr_ready=1, memory returns distinct words -> pc_out 10,11,12... in order, one instr per cycle after fill, count <= 2.
REQ-034 Backpressure: instr_ready=0 after start -> count rises to 4 and holds, imem_req low, instr stable; ready=1 -> 4 consecutive pops, fetching resumes.
REQ-035 Halt: word at 8'h13 has [5:0]=6'h3F -> no requests beyond 8'h14, 8'h13 delivered last, busy falls the cycle after queue empties.
REQ-036 Redirect with 3 entries queued and one in flight -> count 0 next cycle, in-flight word never appears, next pc_out = redirect_pc.
REQ-037 Wrap: start_pc=8'hFE -> pc_out FE, FF, 00, 01.
REQ-038 rst_n asserted mid-stream asynchronously -> all outputs 0 before next edge; start after release replays correctly from start_pc.
